// File: rtl/instr_mem_writer.sv
// instr_mem_writer: packs an MSB-first byte stream into 32-bit words and loads them into an instruction store.
module instr_mem_writer #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IDX_W:0]   word_cnt_i,
  input  logic             abort_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  input  logic [31:0]      addr_i,
  output logic [31:0]      instr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W:0]   wr_idx_o
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
  localparam logic [IDX_W:0] ONE = 1, FULL = DEPTH;
  logic [1:0]       state;
  logic [IDX_W:0]   cnt, wr_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      hold;
  logic [31:0]      store [DEPTH];
  logic             accept, wr_en, unused_addr;
  assign accept       = state == LOAD && byte_valid_i && !abort_i;
  assign wr_en        = accept && byte_cnt == 2'd3;
  assign byte_ready_o = state == LOAD;
  assign busy_o       = state == LOAD;
  assign done_o       = state == DONE;
  assign wr_idx_o     = wr_idx;
  assign instr_o      = store[addr_i[IDX_W+1:2]];
  assign unused_addr  = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_idx   <= '0;
      byte_cnt <= '0;
      hold     <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          cnt      <= word_cnt_i > FULL ? FULL : word_cnt_i;
          wr_idx   <= '0;
          byte_cnt <= '0;
          state    <= word_cnt_i == '0 ? DONE : LOAD;
        end
        LOAD: if (abort_i) begin
          byte_cnt <= '0;
          state    <= IDLE;
        end else if (accept) begin
          if (byte_cnt == 2'd3) begin
            wr_idx   <= wr_idx == FULL ? wr_idx : wr_idx + ONE;
            byte_cnt <= '0;
            if (wr_idx + ONE == cnt) state <= DONE;
          end else begin
            hold     <= {hold[15:0], byte_data_i};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // The fourth byte bypasses the holding register and completes the word on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (wr_en) begin
      store[wr_idx[IDX_W-1:0]] <= {hold, byte_data_i};
    end
  end
endmodule

// File: tb/tb_instr_mem_writer.sv
// tb_instr_mem_writer: scoreboard bench for the byte-stream instruction store loader.
module tb_instr_mem_writer;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, bvalid = 0;
  logic [5:0]  wcnt = '0;
  logic [7:0]  bdata = '0;
  logic [31:0] addr = '0;
  logic        bready, busy, done;
  logic [31:0] instr;
  logic [5:0]  wr_idx;
  int          errors = 0, checks = 0, busy_cnt = 0, done_cnt = 0, b0, d0;
  logic [31:0] model [32];
  logic [37:0] sb [$];
  logic [31:0] w2;

  instr_mem_writer dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .word_cnt_i(wcnt), .abort_i(abort),
    .byte_valid_i(bvalid), .byte_data_i(bdata), .byte_ready_o(bready), .addr_i(addr),
    .instr_o(instr), .busy_o(busy), .done_o(done), .wr_idx_o(wr_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input int idx, input string tag);
    addr = 32'(idx) * 32'd4;
    #1;
    chk(tag, instr, model[idx]);
  endtask

  task automatic start_load(input logic [5:0] n);
    start = 1;
    wcnt  = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      bvalid = 0;
      repeat (2) begin
        @(negedge clk);
        chk("busy_gap", 32'(busy), 32'd1);
      end
    end
    bvalid = 1;
    bdata  = b;
    @(negedge clk);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input bit gappy);
    logic [37:0] e;
    sb.push_back({6'(idx), w});
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gappy && !(idx == 0 && k == 0));
    e = sb.pop_front();
    addr = {24'd0, e[37:32], 2'b00};
    #1;
    chk("word", instr, e[31:0]);
    model[e[37:32]] = e[31:0];
    chk("wr_idx", 32'(wr_idx), 32'(idx + 1));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rd(0, "rst_rd0");
    addr = 32'h7C; #1;
    chk("rst_rd7c", instr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(bready), 32'd0);
    chk("rst_wridx", 32'(wr_idx), 32'd0);
    rst_n = 1;
    @(negedge clk);

    b0 = busy_cnt; d0 = done_cnt;
    start_load(6'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(bready), 32'd1);
    send_word(0, 32'h20080005, 0);
    send_word(1, 32'h01095020, 0);
    bvalid = 0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_ready_end", 32'(bready), 32'd0);
    start = 1; wcnt = 6'd1;
    @(negedge clk);
    start = 0;
    chk("t1_done_once", 32'(done), 32'd0);
    chk("t1_start_in_done", 32'(busy), 32'd0);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd8);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    addr = 32'h04; #1; chk("t1_rd04", instr, 32'h01095020);
    addr = 32'h05; #1; chk("t1_rd05", instr, 32'h01095020);
    rd(0, "t1_rd00");

    b0 = busy_cnt; d0 = done_cnt;
    start_load(6'd2);
    send_word(0, 32'h20080005, 1);
    send_word(1, 32'h01095020, 1);
    bvalid = 0;
    chk("t2_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t2_busy_cycles", 32'(busy_cnt - b0), 32'd22);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    rd(0, "t2_rd0");
    rd(1, "t2_rd1");

    b0 = busy_cnt;
    start_load(6'd40);
    for (int i = 0; i < 32; i++) send_word(i, $urandom, 0);
    bvalid = 0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_wridx", 32'(wr_idx), 32'd32);
    @(negedge clk);
    chk("t3_ready_end", 32'(bready), 32'd0);
    chk("t3_busy_cycles", 32'(busy_cnt - b0), 32'd128);
    addr = 32'h80; #1; chk("t3_wrap", instr, model[0]);
    rd(31, "t3_rd31");

    d0 = done_cnt;
    start_load(6'd3);
    send_word(0, $urandom, 0);
    send_word(1, $urandom, 0);
    w2 = $urandom;
    for (int k = 0; k < 3; k++) send_byte(w2[31-8*k -: 8], 0);
    bdata = w2[7:0]; bvalid = 1; abort = 1;
    @(negedge clk);
    abort = 0; bvalid = 0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(bready), 32'd0);
    chk("t4_wridx", 32'(wr_idx), 32'd2);
    rd(2, "t4_rd2_kept");
    rd(0, "t4_rd0");
    @(negedge clk);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

    start_load(6'd0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_wridx", 32'(wr_idx), 32'd0);
    @(negedge clk);
    chk("t5_done_off", 32'(done), 32'd0);

    start_load(6'd6);
    for (int i = 0; i < 4; i++) send_word(i, $urandom, 0);
    bvalid = 0; start = 1; wcnt = 6'd5;
    @(negedge clk);
    start = 0;
    chk("t6_ign_wridx", 32'(wr_idx), 32'd4);
    chk("t6_ign_busy", 32'(busy), 32'd1);
    send_word(4, $urandom, 0);
    bvalid = 0;
    chk("t6_cnt_kept", 32'(busy), 32'd1);
    chk("t6_no_done", 32'(done), 32'd0);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(bready), 32'd0);
    chk("t6_rst_wridx", 32'(wr_idx), 32'd0);
    for (int i = 0; i < 32; i++) rd(i, "t6_rst_rd");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_post_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
